oled_glyph_scheduler: RTL and testbench

//  Upstream feeder for the dual-OLED glyph driver. Game logic posts glyph requests for

---
 rtl/oled_glyph_scheduler.sv | 169 ++++++++++++++++
 tb/tb_oled_glyph_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_glyph_scheduler.sv
// oled_glyph_scheduler: coalesces per-display glyph requests (latest wins), arbitrates
// round-robin between display 0 and 1, and drives one data/dataReady/address_sel update
// at a time, waiting for the driver to finish its frame before the next one.
// Optional feature macro: SKIP_DUPLICATE_EN (suppress updates that repeat the last glyph
// sent to the same display).
module oled_glyph_scheduler #(
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned BUSY_TIMEOUT = 1024,
  parameter int unsigned GW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_disp,
  input  logic [GW-1:0] req_glyph,
  output logic          req_ready,
  input  logic          drv_busy,
  output logic [GW-1:0] data,
  output logic          dataReady,
  output logic          address_sel,
  output logic          upd_done,
  output logic          timeout_err
);

  localparam int unsigned MaxPh  = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxCnt = (MaxPh > BUSY_TIMEOUT) ? MaxPh : BUSY_TIMEOUT;
  localparam int unsigned CW     = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPulse,
    StHold,
    StWbusy,
    StWdone
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_pend_v;
  logic [GW-1:0]   r_pend_g [2];
  logic            r_rr_ptr;
  logic [GW-1:0]   r_data;
  logic            r_addr_sel;
  logic            r_data_ready;
  logic            r_upd_done;
  logic            r_timeout_err;
  logic            r_req_ready;
`ifdef SKIP_DUPLICATE_EN
  logic [GW-1:0]   r_last_g [2];
`endif

  logic            w_pick;
  logic            w_winner;
  logic [GW-1:0]   w_win_g;
  logic            w_dup;

  // Pick only when idle, the driver is quiet, and something is pending
  always_comb begin
    w_pick   = (r_state == StIdle) && !drv_busy && (|r_pend_v);
    // With a single valid slot, pend_v[1] is exactly the index of that slot
    w_winner = (&r_pend_v) ? r_rr_ptr : r_pend_v[1];
    w_win_g  = r_pend_g[w_winner];
`ifdef SKIP_DUPLICATE_EN
    w_dup    = (w_win_g == r_last_g[w_winner]);
`else
    w_dup    = 1'b0;
`endif
  end

  // Update FSM, pending slots and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_pend_v      <= '0;
      r_pend_g[0]   <= '0;
      r_pend_g[1]   <= '0;
      r_rr_ptr      <= 1'b0;
      r_data        <= '0;
      r_addr_sel    <= 1'b0;
      r_data_ready  <= 1'b0;
      r_upd_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_req_ready   <= 1'b0;
`ifdef SKIP_DUPLICATE_EN
      r_last_g[0]   <= '0;
      r_last_g[1]   <= '0;
`endif
    end else begin
      r_req_ready <= 1'b1;
      r_upd_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_pick) begin
            r_pend_v[w_winner] <= 1'b0;
            if (&r_pend_v) r_rr_ptr <= ~w_winner;
            // A duplicate just retires the slot; the next pick may follow immediately
            if (!w_dup) begin
              r_data       <= w_win_g;
              r_addr_sel   <= w_winner;
              r_data_ready <= 1'b1;
              r_cnt        <= '0;
              r_state      <= StPulse;
`ifdef SKIP_DUPLICATE_EN
              r_last_g[w_winner] <= w_win_g;
`endif
            end
          end
        end
        StPulse: begin
          if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
            r_data_ready <= 1'b0;
            r_cnt        <= '0;
            r_state      <= StHold;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StHold: begin
          if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= StWbusy;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StWbusy: begin
          if (drv_busy) begin
            r_cnt   <= '0;
            r_state <= StWdone;
          end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_upd_done    <= 1'b1;
            r_cnt         <= '0;
            r_state       <= StIdle;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StWdone: begin
          // No timeout here: a full frame legitimately takes a long time
          if (!drv_busy) begin
            r_upd_done <= 1'b1;
            r_cnt      <= '0;
            r_state    <= StIdle;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= StIdle;
        end
      endcase
      // Placed after the pick so a same-cycle request for the winner keeps its slot
      if (req_valid) begin
        r_pend_v[req_disp] <= 1'b1;
        r_pend_g[req_disp] <= req_glyph;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign data        = r_data;
  assign dataReady   = r_data_ready;
  assign address_sel = r_addr_sel;
  assign upd_done    = r_upd_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_oled_glyph_scheduler.sv
// Bench for oled_glyph_scheduler: directed scenarios plus randomized traffic, with every
// output compared each cycle against a timeline-based reference model.
module tb_oled_glyph_scheduler;

  localparam int PulseN = 16;
  localparam int HoldN  = 8;
  localparam int TmoN   = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_disp;
  logic [15:0] req_glyph;
  logic        req_ready;
  logic        drv_busy;
  logic [15:0] data;
  logic        dataReady;
  logic        address_sel;
  logic        upd_done;
  logic        timeout_err;

  oled_glyph_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_disp    (req_disp),
    .req_glyph   (req_glyph),
    .req_ready   (req_ready),
    .drv_busy    (drv_busy),
    .data        (data),
    .dataReady   (dataReady),
    .address_sel (address_sel),
    .upd_done    (upd_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: an update is a timeline measured from its start edge
  bit          m_rdy, m_dr, m_sel, m_done, m_terr, m_act, m_seen, m_rr;
  logic [15:0] m_data;
  bit          m_pv [2];
  logic [15:0] m_pg [2];
  logic [15:0] m_last [2];
  int          m_age, m_wait;

  task automatic model_edge(input bit rn, input bit v, input bit d, input logic [15:0] g,
                            input bit b);
    bit          w;
    bit          both;
    logic [15:0] gl;
    if (!rn) begin
      m_rdy = 0; m_dr = 0; m_sel = 0; m_done = 0; m_terr = 0; m_act = 0; m_rr = 0;
      m_data = '0; m_pv[0] = 0; m_pv[1] = 0; m_pg[0] = '0; m_pg[1] = '0;
      m_last[0] = '0; m_last[1] = '0; m_age = 0; m_wait = 0; m_seen = 0;
      return;
    end
    m_rdy  = 1;
    m_done = 0;
    if (m_act) begin
      if (m_age < PulseN + HoldN) begin
        m_age++;
        m_dr   = (m_age < PulseN);
        m_wait = 0;
        m_seen = 0;
      end else if (!m_seen) begin
        if (b) m_seen = 1;
        else if (m_wait == TmoN - 1) begin
          m_terr = 1; m_done = 1; m_act = 0;
        end else m_wait++;
      end else if (!b) begin
        m_done = 1; m_act = 0;
      end
    end else if (!b && (m_pv[0] || m_pv[1])) begin
      both = m_pv[0] && m_pv[1];
      w    = both ? m_rr : m_pv[1];
      if (both) m_rr = !w;
      m_pv[w] = 0;
      gl = m_pg[w];
`ifdef SKIP_DUPLICATE_EN
      if (gl != m_last[w]) begin
`else
      begin
`endif
        m_act = 1; m_age = 0; m_dr = 1; m_data = gl; m_sel = w; m_last[w] = gl;
      end
    end
    if (v) begin
      m_pv[d] = 1;
      m_pg[d] = g;
    end
  endtask

  // Observation counters over DUT outputs, compared against constants in directed tests
  int   n_rises = 0;
  int   n_done  = 0;
  int   n_drhi  = 0;
  bit   prev_dr = 0;
  logic [15:0] last_rise_data;
  bit   rise_sel_q[$];

  task automatic step(input bit rn, input bit v, input bit d, input logic [15:0] g,
                      input bit b);
    rst = rn; req_valid = v; req_disp = d; req_glyph = g; drv_busy = b;
    model_edge(rn, v, d, g, b);
    @(negedge clk);
    check_val("req_ready", 32'(req_ready), 32'(m_rdy));
    check_val("dataReady", 32'(dataReady), 32'(m_dr));
    check_val("data", 32'(data), 32'(m_data));
    check_val("address_sel", 32'(address_sel), 32'(m_sel));
    check_val("upd_done", 32'(upd_done), 32'(m_done));
    check_val("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (dataReady && !prev_dr) begin
      n_rises++;
      last_rise_data = data;
      rise_sel_q.push_back(address_sel);
    end
    prev_dr = dataReady;
    if (dataReady) n_drhi++;
    if (upd_done) n_done++;
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) step(1, 0, 0, 16'd0, b);
  endtask

  // Let an in-flight update reach the busy wait, run a frame, and finish
  task automatic frame(input int busy_len);
    idle(30, 0);
    idle(busy_len, 1);
    idle(3, 0);
  endtask

  int base, base2;
  int seg;
  bit rb, rv, rd, rn;
  logic [15:0] rg;

  initial begin
    rst = 0; req_valid = 0; req_disp = 0; req_glyph = '0; drv_busy = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'd0, 0);
    check_val("rst_dataReady", 32'(dataReady), 32'd0);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    idle(2, 0);

    // T1: two-edge latency, 16-cycle strobe
    base = n_drhi;
    step(1, 1, 0, 16'd3, 0);
    check_val("t1_lat1", 32'(dataReady), 32'd0);
    step(1, 0, 0, 16'd0, 0);
    check_val("t1_lat2", 32'(dataReady), 32'd1);
    check_val("t1_data", 32'(data), 32'd3);
    idle(30, 0);
    check_val("t1_dr_len", 32'(n_drhi - base), 32'd16);

    // T2: long frame, single done pulse right after busy falls
    base = n_done;
    idle(200, 1);
    check_val("t2_no_done_busy", 32'(n_done - base), 32'd0);
    step(1, 0, 0, 16'd0, 0);
    check_val("t2_done_cycle", 32'(upd_done), 32'd1);
    idle(5, 0);
    check_val("t2_done_once", 32'(n_done - base), 32'd1);

    // T3: coalescing during a live update
    base = n_rises;
    step(1, 1, 0, 16'd7, 0);
    idle(5, 0);
    step(1, 1, 0, 16'd1, 0);
    step(1, 1, 0, 16'd2, 0);
    check_val("t3_live_data", 32'(data), 32'd7);
    idle(25, 0); idle(10, 1); idle(3, 0);
    frame(10);
    check_val("t3_rises", 32'(n_rises - base), 32'd2);
    check_val("t3_follow_data", 32'(last_rise_data), 32'd2);

    // T4: contention built up while busy blocks picks in idle
    idle(2, 1);
    step(1, 1, 0, 16'd1, 1);
    step(1, 1, 1, 16'd2, 1);
    idle(3, 1);
    check_val("t4_busy_block", 32'(dataReady), 32'd0);
    rise_sel_q.delete();
    frame(10);
    frame(10);
    check_val("t4_n_upd", 32'(rise_sel_q.size()), 32'd2);
    if (rise_sel_q.size() == 2) begin
      check_val("t4_first", 32'(rise_sel_q[0]), 32'd0);
      check_val("t4_second", 32'(rise_sel_q[1]), 32'd1);
    end

    // T5: busy never rises -> timeout, then normal service resumes
    step(1, 1, 1, 16'd9, 0);
    idle(1060, 0);
    check_val("t5_terr", 32'(timeout_err), 32'd1);
    base = n_rises;
    step(1, 1, 0, 16'd4, 0);
    frame(10);
    check_val("t5_served", 32'(n_rises - base), 32'd1);

    // T6: reset mid-pulse drops the strobe and discards pending work
    step(1, 1, 1, 16'd5, 0);
    idle(4, 0);
    step(1, 1, 0, 16'd6, 0);
    step(0, 0, 0, 16'd0, 0);
    check_val("t6_dr_drop", 32'(dataReady), 32'd0);
    check_val("t6_terr_clr", 32'(timeout_err), 32'd0);
    base = n_rises;
    idle(25, 0);
    check_val("t6_pend_clr", 32'(n_rises - base), 32'd0);

    // Repeat of the same glyph to the same display
    base = n_rises;
    step(1, 1, 1, 16'd5, 0);
    frame(10);
    step(1, 1, 1, 16'd5, 0);
    frame(10);
`ifdef SKIP_DUPLICATE_EN
    check_val("dup_rises", 32'(n_rises - base), 32'd1);
`else
    check_val("dup_rises", 32'(n_rises - base), 32'd2);
`endif

    // Randomized traffic with a free-running busy waveform
    base2 = n_rises;
    seg = 0; rb = 0;
    for (int i = 0; i < 4000 && n_errs < 30; i++) begin
      if (seg == 0) begin
        rb  = !rb;
        seg = rb ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 40));
      end
      seg--;
      rv = ($urandom_range(0, 5) == 0);
      rd = 1'($urandom);
      rg = 16'($urandom_range(0, 7));
      rn = ($urandom_range(0, 1499) != 0);
      step(rn, rv, rd, rg, rb);
    end
    check_val("rand_activity", 32'(n_rises > base2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
